// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one external 16-bit ALU between two requesters,
// with registered ALU operands and a valid/ready response port tagged by requester id.
module alu_share_arbiter #(
    parameter int DATA_W = 16,
    parameter int OP_W   = 4,
    parameter int SH_W   = 5,
    parameter int OP_MAX = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [OP_W-1:0]   req0_opcode,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [SH_W-1:0]   req0_shamt,
    input  logic [OP_W-1:0]   req1_opcode,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [SH_W-1:0]   req1_shamt,
    output logic [OP_W-1:0]   alu_opcode,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [SH_W-1:0]   alu_shift,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_flags,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic [3:0]        rsp_flags,
    output logic              rsp_err
);
    localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2;
    logic [1:0]        state;
    logic              rr_ptr;
    logic              id_r;
    logic [OP_W-1:0]   op_r;
    logic [DATA_W-1:0] a_r, b_r, res_r;
    logic [SH_W-1:0]   sh_r;
    logic [3:0]        flg_r;
    logic              err_r;
    logic              g0, g1;
    // rr_ptr names the preferred requester; the other wins only when the preferred one is idle
    always_comb begin
        g0 = req_valid[0] & (~rr_ptr | ~req_valid[1]);
        g1 = req_valid[1] & (rr_ptr | ~req_valid[0]);
        req_ready = (rst_n && state == IDLE) ? {g1, g0} : 2'b00;
    end
    assign alu_opcode = op_r;
    assign alu_in1    = a_r;
    assign alu_in2    = b_r;
    assign alu_shift  = sh_r;
    assign rsp_valid  = state == RESP;
    assign rsp_id     = id_r;
    assign rsp_result = res_r;
    assign rsp_flags  = flg_r;
    assign rsp_err    = err_r;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= 1'b0;
            id_r   <= 1'b0;
            op_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            sh_r   <= '0;
            res_r  <= '0;
            flg_r  <= '0;
            err_r  <= 1'b0;
        end else if (state == IDLE && |req_ready) begin
            state <= EXEC;
            id_r  <= req_ready[1];
            op_r  <= req_ready[1] ? req1_opcode : req0_opcode;
            a_r   <= req_ready[1] ? req1_a : req0_a;
            b_r   <= req_ready[1] ? req1_b : req0_b;
            sh_r  <= req_ready[1] ? req1_shamt : req0_shamt;
        end else if (state == EXEC) begin
            state <= RESP;
            res_r <= alu_result;
            flg_r <= alu_flags;
            err_r <= op_r > OP_W'(OP_MAX);
        end else if (state == RESP && rsp_ready) begin
            state  <= IDLE;
            rr_ptr <= ~id_r;
        end
    end
endmodule
